// File: rtl/uart_bootloader_pkg.sv
// Shared constants and state encodings for the UART bootloader and its receiver.
package uart_bootloader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK,
    DONE
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_bootloader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte_valid strobe.
module uart_rx
  import uart_bootloader_pkg::*;
#(
  parameter int DIV = 2604
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int CW = $clog2(DIV + 1);

  logic [1:0]    rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  logic [CW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // rx_sync[1] is the metastability-safe copy; rx_prev holds it one cycle back for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync    <= 2'b11;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      rx_sync    <= {rx_sync[0], rx};
      rx_prev    <= rx_sync[1];
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync[1]) begin
            state <= RX_START;
            tick  <= '0;
          end
        end
        RX_START: begin
          if (tick == CW'(DIV / 2 - 1)) begin
            tick    <= '0;
            bit_idx <= '0;
            state   <= rx_sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick == CW'(DIV - 1)) begin
            tick    <= '0;
            shift   <= {rx_sync[1], shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RX_STOP: begin
          // A low stop bit silently drops the byte
          if (tick == CW'(DIV - 1)) begin
            tick  <= '0;
            state <= RX_IDLE;
            if (rx_sync[1]) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bootloader.sv
// Receives a framed image over UART, writes it word by word to memory, then releases the CPU.
module uart_bootloader
  import uart_bootloader_pkg::*;
#(
  parameter int CLOCK_FREQ   = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int ADDR_WIDTH   = 10,
  parameter int TIMEOUT_BITS = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  boot_skip,
  output logic                  cpu_reset_o,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata
);

  localparam int DIV            = CLOCK_FREQ / BIT_RATE;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * DIV;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

  boot_state_t           state;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic [TW-1:0]         timer;
  logic [7:0]            checksum;
  logic [7:0]            cnt_lo;
  logic [15:0]           words_left;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  assign cpu_reset_o = (state != DONE);
  assign boot_done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      boot_error <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      timer      <= '0;
      checksum   <= '0;
      cnt_lo     <= '0;
      words_left <= '0;
      word_addr  <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else begin
      mem_we     <= 1'b0;
      boot_error <= 1'b0;
      case (state)
        WAIT_SYNC: begin
          timer <= '0;
          if (boot_skip) begin
            state <= DONE;
          end else if (byte_valid && byte_data == SYNC_BYTE) begin
            state    <= CNT_LO;
            checksum <= '0;
          end
        end
        DONE: ;
        default: begin
          // Receiving states share the inter-byte timeout; any byte restarts it
          if (byte_valid) begin
            timer <= '0;
            case (state)
              CNT_LO: begin
                cnt_lo <= byte_data;
                state  <= CNT_HI;
              end
              CNT_HI: begin
                if ({byte_data, cnt_lo} == 16'd0) begin
                  state <= CHECK;
                end else if ({1'b0, byte_data, cnt_lo} > CAPACITY) begin
                  boot_error <= 1'b1;
                  state      <= WAIT_SYNC;
                end else begin
                  words_left <= {byte_data, cnt_lo};
                  word_addr  <= '0;
                  byte_idx   <= '0;
                  state      <= DATA;
                end
              end
              DATA: begin
                checksum <= checksum + byte_data;
                word_buf <= {byte_data, word_buf[23:8]};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  mem_we     <= 1'b1;
                  mem_addr   <= word_addr;
                  mem_wdata  <= {byte_data, word_buf};
                  word_addr  <= word_addr + 1'b1;
                  words_left <= words_left - 16'd1;
                  if (words_left == 16'd1) state <= CHECK;
                end
              end
              CHECK: begin
                if (byte_data == checksum) begin
                  state <= DONE;
                end else begin
                  boot_error <= 1'b1;
                  state      <= WAIT_SYNC;
                end
              end
              default: state <= WAIT_SYNC;
            endcase
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            boot_error <= 1'b1;
            timer      <= '0;
            state      <= WAIT_SYNC;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
